mer_meter_4ask: RTL and testbench
=================================

// Module: mer_meter_4ask
// PURPOSE
//  Downstream of the 4-ASK SRRC filter test path: takes the 1s17 filter output, decimates it to
//  one sample per symbol, slices to the nearest 4-ASK level and accumulates signal/error stats.
//  Per window of 2^LOG2_N symbols it reports the estimated reference level and the mean
//  squared error. MER = 10log10(5*ref_level^2 / mean_err_sq) is computed off-chip.
// PARAMETERS
//  LOG2_N   12  log2 of symbols per measurement window (legal 2..16)
// PORTS
//  sys_clk      in   1   system clock; all logic on posedge
//  reset_n      in   1   asynchronous active-low reset
//  sam_clk_ena  in   1   one-cycle sample strobe (4 per symbol)
//  sym_clk_ena  in   1   one-cycle symbol strobe, coincident with a sam_clk_ena
//  enable       in   1   1 = measure; 0 = return to IDLE, clear accumulators
//  phase_sel    in   2   which sample of the symbol (0..3 after symbol strobe) is sliced
//  sig_in       in   18  signed 1s17 matched-filter output
//  dec_sym      out  2   registered slicer decision: 00=-3a 01=-a 10=+a 11=+3a
//  sym_valid    out  1   1-cycle pulse, dec_sym updated
//  ref_level    out  17  unsigned 0s17 estimate of a (inner level)
//  mean_err_sq  out  36  unsigned 2s34 mean of (x-dec)^2 over last window
//  meas_valid   out  1   1-cycle pulse, ref_level/mean_err_sq updated
//  busy         out  1   1 in ACQ or RUN
// BEHAVIOUR
//  Reset: every output and internal register = 0; state IDLE.
//  Phase counter: cleared to 0 when sam_clk_ena&sym_clk_ena, else +1 (mod 4) per sam_clk_ena.
//  Strobe: sam_clk_ena & (phase == phase_sel); phase_sel sampled each strobe, change is glitch-free.
//  Pipe (from strobe cycle T): T+1 |x| and decision registered (dec_sym, sym_valid);
//   T+2 error e=x-dec and e^2 registered; T+3 accumulators update. Pipeline carries a 'last' tag.
//  |x|: sig_in=-131072 saturates to 131071. dec level: |x| < 2*ref_level -> a else 3a; sign of x;
//   x=0 -> +a. a = ref_level, 3a = 3*ref_level saturated to 131071.
//  e computed 19-bit, saturated to 18-bit signed before squaring; e^2 is 36-bit 2s34.
//  acc_abs width 17+LOG2_N, acc_err width 36+LOG2_N; no overflow possible by width.
//  FSM: IDLE -(enable)-> ACQ -(window end)-> RUN -(window end)-> RUN; any state -(!enable)-> IDLE.
//   IDLE: no accumulation, sym_count=0, accumulators=0, outputs hold last values.
//   ACQ: accumulate |x| only; sym_valid still pulses; at window end ref_level=acc_abs>>(LOG2_N+1),
//    no meas_valid.
//   RUN: accumulate |x| and e^2; at window end (last-tagged sample reaching T+3):
//    ref_level=acc_abs'>>(LOG2_N+1), mean_err_sq=acc_err'>>LOG2_N (acc' includes last term),
//    meas_valid=1 for one cycle, accumulators load 0 same cycle (no sample lost).
//  sym_count: increments per strobe in ACQ/RUN; 'last' when count==2^LOG2_N-1, then wraps to 0.
//  enable low mid-window: in-flight pipe samples discarded, partial window dropped, no meas_valid.
//  Reset mid-operation: immediate clear, as at power-up.
//  Strobe while previous sample in pipe: fully pipelined, one strobe per cycle sustainable.
// STRUCTURE
//  Shared package: 4-ASK symbol encoding constants, 1s17 width constant, FSM state enum.
//  One sub-module: mer_slicer_4ask (abs/saturate, threshold compare, decision level, error).
//  Top holds phase counter, FSM, sym_count, accumulators, output registers.
// TESTING (LOG2_N=4 unless noted; symbols on every 4th sample at phase 2, other phases = 0x1FFFF)
//  1 reset_n low with sig_in toggling -> all outputs 0, busy=0, no pulses.
//  2 ideal levels a=16384 (+-16384,+-49152 random), phase_sel=2 -> after 16 syms ref_level=16384;
//    each later window meas_valid, mean_err_sq=0, dec_sym matches stimulus.
//  3 same + offset +1024 on every symbol -> mean_err_sq=1048576, decisions unchanged.
//  4 phase_sel=0 with stimulus on phase 2 -> garbage slices, mean_err_sq!=0; back to 2 -> 0 next full window.
//  5 sig_in=-131072 only -> |x| saturates 131071, ref_level=65535, dec_sym=00.
//  6 enable low at symbol 7 of RUN window -> no meas_valid, busy=0; re-enable -> ACQ again, first
//    meas_valid 32 symbols later; repeat with reset_n pulse mid-window -> outputs 0.

Source files
------------

// File: rtl/mer_meter_4ask_pkg.sv
// Shared constants for the 4-ASK MER meter: sample widths, symbol codes and FSM states.
package mer_meter_4ask_pkg;

    localparam int SIG_W = 18;   // 1s17 filter output
    localparam int LVL_W = 17;   // unsigned 0s17 magnitudes
    localparam int ESQ_W = 36;   // unsigned 2s34 squared error

    localparam logic [LVL_W-1:0] LVL_MAX = 17'd131071;

    localparam logic [1:0] SYM_M3A = 2'b00;
    localparam logic [1:0] SYM_M1A = 2'b01;
    localparam logic [1:0] SYM_P1A = 2'b10;
    localparam logic [1:0] SYM_P3A = 2'b11;

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_ACQ  = 2'd1;
    localparam fsm_state_t ST_RUN  = 2'd2;

endpackage

// File: rtl/mer_meter_4ask_if.sv
// Bundle of strobes, sample input and measurement results for the MER meter.
interface mer_meter_4ask_if;
    import mer_meter_4ask_pkg::*;

    // Handshake: sam/sym strobes and sym_valid/meas_valid are valid-only single-cycle
    // qualifiers with no back-pressure; the consumer must accept every pulse.
    logic                    sam_clk_ena;
    logic                    sym_clk_ena;
    logic                    enable;
    logic [1:0]              phase_sel;
    logic signed [SIG_W-1:0] sig_in;
    logic [1:0]              dec_sym;
    logic                    sym_valid;
    logic [LVL_W-1:0]        ref_level;
    logic [ESQ_W-1:0]        mean_err_sq;
    logic                    meas_valid;
    logic                    busy;
    logic [1:0]              state_dbg;

    modport master (
        output sam_clk_ena, sym_clk_ena, enable, phase_sel, sig_in,
        input  dec_sym, sym_valid, ref_level, mean_err_sq, meas_valid, busy, state_dbg
    );

    modport slave (
        input  sam_clk_ena, sym_clk_ena, enable, phase_sel, sig_in,
        output dec_sym, sym_valid, ref_level, mean_err_sq, meas_valid, busy, state_dbg
    );

endinterface

// File: rtl/mer_slicer_4ask.sv
// Combinational 4-ASK slicer: magnitude, nearest-level decision and saturated error.
module mer_slicer_4ask
    import mer_meter_4ask_pkg::*;
(
    input  logic signed [SIG_W-1:0] x,
    input  logic [LVL_W-1:0]        ref_level,
    output logic [LVL_W-1:0]        abs_x,
    output logic [1:0]              dec_sym,
    output logic signed [SIG_W-1:0] dec_lvl,
    input  logic signed [SIG_W-1:0] x_q,
    input  logic signed [SIG_W-1:0] dec_lvl_q,
    output logic signed [SIG_W-1:0] err
);

    logic             neg;
    logic             inner;
    logic [LVL_W:0]   thresh;
    logic [LVL_W+1:0] three_a;
    logic [LVL_W-1:0] outer_lvl;
    logic [LVL_W-1:0] mag;
    logic [SIG_W:0]   err_wide;

    always_comb begin
        neg = x[SIG_W-1];
        // -2^17 has no positive twin in 1s17, so it clamps to the largest magnitude
        if (x == {1'b1, {LVL_W{1'b0}}}) begin
            abs_x = LVL_MAX;
        end else if (neg) begin
            abs_x = LVL_W'(-x);
        end else begin
            abs_x = LVL_W'(x);
        end

        thresh    = {ref_level, 1'b0};
        three_a   = {2'b00, ref_level} + {1'b0, ref_level, 1'b0};
        outer_lvl = (three_a > {2'b00, LVL_MAX}) ? LVL_MAX : three_a[LVL_W-1:0];
        inner     = ({1'b0, abs_x} < thresh) || (x == '0);
        mag       = inner ? ref_level : outer_lvl;
        dec_lvl   = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});

        if (neg) begin
            dec_sym = inner ? SYM_M1A : SYM_M3A;
        end else begin
            dec_sym = inner ? SYM_P1A : SYM_P3A;
        end

        err_wide = {x_q[SIG_W-1], x_q} - {dec_lvl_q[SIG_W-1], dec_lvl_q};
        if (err_wide[SIG_W] != err_wide[SIG_W-1]) begin
            err = err_wide[SIG_W] ? $signed({1'b1, {LVL_W{1'b0}}}) : $signed({1'b0, LVL_MAX});
        end else begin
            err = $signed(err_wide[SIG_W-1:0]);
        end
    end

endmodule

// File: rtl/mer_meter_4ask.sv
// 4-ASK MER meter: symbol-rate decimation, slicing pipeline, windowed level/error statistics.
module mer_meter_4ask
    import mer_meter_4ask_pkg::*;
#(
    parameter int LOG2_N = 12
)
(
    input  logic            sys_clk,
    input  logic            reset_n,
    mer_meter_4ask_if.slave bus
);

    localparam int ABS_ACC_W = LVL_W + LOG2_N;
    localparam int ERR_ACC_W = ESQ_W + LOG2_N;
    localparam logic [LOG2_N-1:0] LAST_CNT = '1;

    fsm_state_t              state_q;
    logic [1:0]              phase_q;
    logic [LOG2_N-1:0]       sym_count;
    logic                    strobe;
    logic                    take;

    logic [LVL_W-1:0]        slc_abs;
    logic [1:0]              slc_dec;
    logic signed [SIG_W-1:0] slc_lvl;
    logic signed [SIG_W-1:0] slc_err;
    logic signed [ESQ_W-1:0] esq;

    logic                    s1_valid, s1_last;
    logic signed [SIG_W-1:0] s1_x, s1_lvl;
    logic [LVL_W-1:0]        s1_abs;
    logic                    s2_valid, s2_last;
    logic [LVL_W-1:0]        s2_abs;
    logic [ESQ_W-1:0]        s2_esq;

    logic [ABS_ACC_W-1:0]    acc_abs, abs_sum;
    logic [ERR_ACC_W-1:0]    acc_err, err_sum;

    logic [1:0]              dec_sym_q;
    logic                    sym_valid_q;
    logic [LVL_W-1:0]        ref_level_q;
    logic [ESQ_W-1:0]        mean_err_sq_q;
    logic                    meas_valid_q;

    assign strobe  = bus.sam_clk_ena && (phase_q == bus.phase_sel);
    assign take    = strobe && bus.enable && (state_q != ST_IDLE);
    assign esq     = slc_err * slc_err;
    assign abs_sum = acc_abs + ABS_ACC_W'(s2_abs);
    assign err_sum = acc_err + ERR_ACC_W'(s2_esq);

    mer_slicer_4ask u_slicer (
        .x         (bus.sig_in),
        .ref_level (ref_level_q),
        .abs_x     (slc_abs),
        .dec_sym   (slc_dec),
        .dec_lvl   (slc_lvl),
        .x_q       (s1_x),
        .dec_lvl_q (s1_lvl),
        .err       (slc_err)
    );

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= 2'd0;
        end else if (bus.sam_clk_ena) begin
            phase_q <= bus.sym_clk_ena ? 2'd0 : phase_q + 2'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            sym_count     <= '0;
            s1_valid      <= 1'b0;
            s1_last       <= 1'b0;
            s1_x          <= '0;
            s1_lvl        <= '0;
            s1_abs        <= '0;
            s2_valid      <= 1'b0;
            s2_last       <= 1'b0;
            s2_abs        <= '0;
            s2_esq        <= '0;
            acc_abs       <= '0;
            acc_err       <= '0;
            dec_sym_q     <= 2'b00;
            sym_valid_q   <= 1'b0;
            ref_level_q   <= '0;
            mean_err_sq_q <= '0;
            meas_valid_q  <= 1'b0;
        end else begin
            sym_valid_q  <= 1'b0;
            meas_valid_q <= 1'b0;
            if (!bus.enable) begin
                // Dropping enable abandons the window and anything still in the pipe
                state_q   <= ST_IDLE;
                sym_count <= '0;
                s1_valid  <= 1'b0;
                s2_valid  <= 1'b0;
                acc_abs   <= '0;
                acc_err   <= '0;
            end else begin
                if (state_q == ST_IDLE) begin
                    state_q <= ST_ACQ;
                end

                s1_valid <= take;
                s1_last  <= take && (sym_count == LAST_CNT);
                if (take) begin
                    sym_count   <= sym_count + 1'b1;
                    s1_x        <= bus.sig_in;
                    s1_lvl      <= slc_lvl;
                    s1_abs      <= slc_abs;
                    dec_sym_q   <= slc_dec;
                    sym_valid_q <= 1'b1;
                end

                s2_valid <= s1_valid;
                s2_last  <= s1_last;
                s2_abs   <= s1_abs;
                s2_esq   <= $unsigned(esq);

                // The closing sample is folded into the result and the accumulators
                // restart from zero, so the next window loses nothing.
                if (s2_valid) begin
                    if (s2_last) begin
                        acc_abs     <= '0;
                        acc_err     <= '0;
                        ref_level_q <= LVL_W'(abs_sum >> (LOG2_N + 1));
                        if (state_q == ST_RUN) begin
                            mean_err_sq_q <= ESQ_W'(err_sum >> LOG2_N);
                            meas_valid_q  <= 1'b1;
                        end
                        state_q <= ST_RUN;
                    end else begin
                        acc_abs <= abs_sum;
                        if (state_q == ST_RUN) begin
                            acc_err <= err_sum;
                        end
                    end
                end
            end
        end
    end

    assign bus.dec_sym     = dec_sym_q;
    assign bus.sym_valid   = sym_valid_q;
    assign bus.ref_level   = ref_level_q;
    assign bus.mean_err_sq = mean_err_sq_q;
    assign bus.meas_valid  = meas_valid_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_mer_meter_4ask.sv
// Directed bench for mer_meter_4ask with LOG2_N=4: scoreboarded decisions and window results.
module tb_mer_meter_4ask;
    import mer_meter_4ask_pkg::*;

    localparam int LOG2_N = 4;
    localparam int N_SYM  = 1 << LOG2_N;
    localparam logic [17:0] FILL  = 18'h1FFFF;
    localparam logic [17:0] MIN_X = 18'h20000;

    localparam int DM_SIGN  = 0;  // ref=0: outer level, sign only
    localparam int DM_LEVEL = 1;  // ref=a: decision equals sent level
    localparam int DM_INNER = 2;  // ref large: always inner level
    localparam int DM_P3A   = 3;
    localparam int DM_M3A   = 4;

    // clock / reset
    logic sys_clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    mer_meter_4ask_if bus();

    mer_meter_4ask #(.LOG2_N(LOG2_N)) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks    = 0;
    int failures  = 0;
    int meas_seen = 0;
    logic [1:0]  dec_q[$];
    logic [52:0] exp_q[$];
    logic [1:0]  mon_dec;
    logic [52:0] mon_meas;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic sam, input logic sym, input logic [17:0] x);
        bus.sam_clk_ena = sam;
        bus.sym_clk_ena = sym;
        bus.sig_in      = x;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 18'd0);
    endtask

    task automatic send_sym(input logic [17:0] x, input logic [17:0] fill);
        drive(1'b1, 1'b1, fill);
        drive(1'b1, 1'b0, fill);
        drive(1'b1, 1'b0, fill);
        drive(1'b1, 1'b0, x);
    endtask

    function automatic int lvl_val(input int idx);
        case (idx)
            0:       return -49152;
            1:       return -16384;
            2:       return 16384;
            default: return 49152;
        endcase
    endfunction

    function automatic logic [1:0] exp_dec(input int mode, input int idx);
        case (mode)
            DM_SIGN:  return (idx >= 2) ? 2'b11 : 2'b00;
            DM_LEVEL: return 2'(idx);
            DM_INNER: return (idx >= 2) ? 2'b10 : 2'b01;
            DM_P3A:   return 2'b11;
            default:  return 2'b00;
        endcase
    endfunction

    // Each window carries every level four times in shuffled order.
    task automatic send_window(input int n_syms, input int offset, input int mode,
                               input logic all_min, input logic push_meas,
                               input logic [16:0] e_ref, input logic [35:0] e_mse);
        int lv[N_SYM];
        int j;
        int t;
        logic [17:0] x;
        for (int i = 0; i < N_SYM; i++) lv[i] = i % 4;
        for (int i = N_SYM - 1; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = lv[i];
            lv[i] = lv[j];
            lv[j] = t;
        end
        if (push_meas) exp_q.push_back({e_ref, e_mse});
        for (int i = 0; i < n_syms; i++) begin
            x = all_min ? MIN_X : 18'(lvl_val(lv[i]) + offset);
            dec_q.push_back(exp_dec(mode, lv[i]));
            send_sym(x, all_min ? MIN_X : FILL);
        end
    endtask

    // scoreboard
    always @(negedge sys_clk) begin
        if (reset_n) begin
            if (bus.sym_valid) begin
                check_eq("sym_valid_expected", 64'(bus.sym_valid), 64'(dec_q.size() != 0));
                if (dec_q.size() != 0) begin
                    mon_dec = dec_q.pop_front();
                    check_eq("dec_sym", 64'(bus.dec_sym), 64'(mon_dec));
                end
            end
            if (bus.meas_valid) begin
                meas_seen++;
                check_eq("meas_valid_expected", 64'(bus.meas_valid), 64'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    mon_meas = exp_q.pop_front();
                    check_eq("ref_level", 64'(bus.ref_level), 64'(mon_meas[52:36]));
                    check_eq("mean_err_sq", 64'(bus.mean_err_sq), 64'(mon_meas[35:0]));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_dec_sym"}, 64'(bus.dec_sym), 64'd0);
        check_eq({tag, "_sym_valid"}, 64'(bus.sym_valid), 64'd0);
        check_eq({tag, "_ref_level"}, 64'(bus.ref_level), 64'd0);
        check_eq({tag, "_mean_err_sq"}, 64'(bus.mean_err_sq), 64'd0);
        check_eq({tag, "_meas_valid"}, 64'(bus.meas_valid), 64'd0);
        check_eq({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    int m0;
    logic [5:0] rst_or;

    initial begin
        bus.sam_clk_ena = 1'b0;
        bus.sym_clk_ena = 1'b0;
        bus.enable      = 1'b1;
        bus.phase_sel   = 2'd2;
        bus.sig_in      = '0;
        rst_or          = '0;

        // 1: held in reset with activity on the inputs
        #2;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, (i % 4) == 0, i[0] ? FILL : MIN_X);
            rst_or = rst_or | {|bus.dec_sym, bus.sym_valid, |bus.ref_level,
                               |bus.mean_err_sq, bus.meas_valid, bus.busy};
        end
        check_eq("rst_any_output", 64'(rst_or), 64'd0);
        check_all_zero("rst");
        bus.enable = 1'b0;
        reset_n    = 1'b1;
        idle(3);

        // 2: ideal levels, acquisition then two clean windows
        bus.enable = 1'b1;
        send_window(N_SYM, 0, DM_SIGN, 1'b0, 1'b0, 17'd0, 36'd0);
        idle(4);
        check_eq("acq_ref_level", 64'(bus.ref_level), 64'd16384);
        check_eq("acq_busy", 64'(bus.busy), 64'd1);
        check_eq("acq_to_run_state", 64'(bus.state_dbg), 64'(ST_RUN));
        check_eq("acq_no_meas", 64'(meas_seen), 64'd0);
        send_window(N_SYM, 0, DM_LEVEL, 1'b0, 1'b1, 17'd16384, 36'd0);
        send_window(N_SYM, 0, DM_LEVEL, 1'b0, 1'b1, 17'd16384, 36'd0);

        // 3: constant +1024 offset
        send_window(N_SYM, 1024, DM_LEVEL, 1'b0, 1'b1, 17'd16384, 36'd1048576);
        send_window(N_SYM, 1024, DM_LEVEL, 1'b0, 1'b1, 17'd16384, 36'd1048576);
        idle(4);
        check_eq("offset_windows_seen", 64'(meas_seen), 64'd4);

        // 4: wrong phase slices the 0x1FFFF filler, then recovery
        bus.phase_sel = 2'd0;
        send_window(N_SYM, 0, DM_P3A, 1'b0, 1'b1, 17'd65535, 36'd6710722561);
        bus.phase_sel = 2'd2;
        send_window(N_SYM, 0, DM_INNER, 1'b0, 1'b1, 17'd16384, 36'd1342111745);
        send_window(N_SYM, 0, DM_LEVEL, 1'b0, 1'b1, 17'd16384, 36'd0);

        // 5: full-scale negative input, then 3a saturation
        send_window(N_SYM, 0, DM_M3A, 1'b1, 1'b1, 17'd65535, 36'd6710886400);
        send_window(N_SYM, 0, DM_M3A, 1'b1, 1'b1, 17'd65535, 36'd1);
        idle(4);
        check_eq("sat_ref_level", 64'(bus.ref_level), 64'd65535);

        // 6: enable dropped mid-window, re-acquire, then reset mid-window
        send_window(7, 0, DM_INNER, 1'b0, 1'b0, 17'd0, 36'd0);
        bus.enable = 1'b0;
        idle(1);
        check_eq("disable_busy", 64'(bus.busy), 64'd0);
        m0 = meas_seen;
        idle(10);
        check_eq("disable_no_meas", 64'(meas_seen), 64'(m0));
        check_eq("disable_holds_ref", 64'(bus.ref_level), 64'd65535);

        bus.enable = 1'b1;
        send_window(N_SYM, 0, DM_INNER, 1'b0, 1'b0, 17'd0, 36'd0);
        idle(4);
        check_eq("reacq_no_meas", 64'(meas_seen), 64'(m0));
        check_eq("reacq_ref_level", 64'(bus.ref_level), 64'd16384);
        send_window(N_SYM, 0, DM_LEVEL, 1'b0, 1'b1, 17'd16384, 36'd0);
        idle(4);
        check_eq("reacq_first_meas", 64'(meas_seen), 64'(m0 + 1));

        send_window(5, 0, DM_LEVEL, 1'b0, 1'b0, 17'd0, 36'd0);
        idle(2);
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        check_eq("midrst_state", 64'(bus.state_dbg), 64'(ST_IDLE));
        idle(2);
        reset_n = 1'b1;
        idle(8);

        check_eq("dec_q_drained", 64'(dec_q.size()), 64'd0);
        check_eq("exp_q_drained", 64'(exp_q.size()), 64'd0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
